// File: rtl/elevator_controller.sv
// elevator_controller: three-floor SCAN scheduler that latches calls, times travel and door dwell.
// Optional build macro EMERGENCY_STOP_EN adds an `emergency` input that freezes motion and request latching.
module elevator_controller #(
  parameter logic [1:0] ST_FLOOR      = 2'b00,
  parameter logic [1:0] ND_FLOOR      = 2'b01,
  parameter logic [1:0] RD_FLOOR      = 2'b10,
  parameter int         TRAVEL_CYCLES = 8,
  parameter int         DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st_button,
  input  logic       nd_button,
  input  logic       rd_button,
`ifdef EMERGENCY_STOP_EN
  input  logic       emergency,
`endif
  output logic [1:0] state,
  output logic       open_door,
  output logic       moving,
  output logic       direction,
  output logic [2:0] pending
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  logic [1:0]    fsm, fsm_nxt;
  logic [TW-1:0] travel_cnt, travel_cnt_nxt;
  logic [DW-1:0] door_cnt, door_cnt_nxt;
  logic [1:0]    state_nxt;
  logic          open_door_nxt, moving_nxt, direction_nxt;
  logic [2:0]    pending_nxt;
  logic [1:0]    cur_idx, new_idx;
  logic [2:0]    set_mask, clr_mask;

  // Floors are handled internally as indices 0..2 so pending bits line up with them.
  function automatic logic [1:0] idx_of(input logic [1:0] enc);
    if (enc == RD_FLOOR)      return 2'd2;
    else if (enc == ND_FLOOR) return 2'd1;
    else                      return 2'd0;
  endfunction

  function automatic logic [1:0] enc_of(input logic [1:0] idx);
    case (idx)
      2'd2:    return RD_FLOOR;
      2'd1:    return ND_FLOOR;
      default: return ST_FLOOR;
    endcase
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    fsm_nxt        = fsm;
    travel_cnt_nxt = travel_cnt;
    door_cnt_nxt   = door_cnt;
    state_nxt      = state;
    open_door_nxt  = open_door;
    moving_nxt     = moving;
    direction_nxt  = direction;
    cur_idx        = idx_of(state);
    new_idx        = cur_idx;
    set_mask       = {rd_button, nd_button, st_button};
    clr_mask       = 3'b000;

    case (fsm)
      IDLE: begin
        if (pending[cur_idx]) begin
          fsm_nxt           = DOOR;
          open_door_nxt     = 1'b1;
          door_cnt_nxt      = DOOR_LOAD;
          clr_mask[cur_idx] = 1'b1;
        end else if (|(pending & above_mask(cur_idx)) &&
                     (direction || !(|(pending & below_mask(cur_idx))))) begin
          fsm_nxt        = MOVE;
          moving_nxt     = 1'b1;
          direction_nxt  = 1'b1;
          travel_cnt_nxt = TRAVEL_LOAD;
        end else if (|(pending & below_mask(cur_idx))) begin
          fsm_nxt        = MOVE;
          moving_nxt     = 1'b1;
          direction_nxt  = 1'b0;
          travel_cnt_nxt = TRAVEL_LOAD;
        end
      end

      MOVE: begin
        if (travel_cnt != '0) begin
          travel_cnt_nxt = travel_cnt - TW'(1);
        end else begin
          if (direction) new_idx = (cur_idx == 2'd2) ? 2'd2 : cur_idx + 2'd1;
          else           new_idx = (cur_idx == 2'd0) ? 2'd0 : cur_idx - 2'd1;
          state_nxt = enc_of(new_idx);
          // Arrival decision is made against the floor just reached.
          if (pending[new_idx]) begin
            fsm_nxt           = DOOR;
            moving_nxt        = 1'b0;
            open_door_nxt     = 1'b1;
            door_cnt_nxt      = DOOR_LOAD;
            clr_mask[new_idx] = 1'b1;
          end else if (|(pending & (direction ? above_mask(new_idx) : below_mask(new_idx)))) begin
            travel_cnt_nxt = TRAVEL_LOAD;
          end else begin
            fsm_nxt    = IDLE;
            moving_nxt = 1'b0;
          end
        end
      end

      DOOR: begin
        set_mask[cur_idx] = 1'b0;
        if (door_cnt != '0) begin
          door_cnt_nxt = door_cnt - DW'(1);
        end else begin
          fsm_nxt       = IDLE;
          open_door_nxt = 1'b0;
        end
      end

      default: begin
        fsm_nxt       = IDLE;
        moving_nxt    = 1'b0;
        open_door_nxt = 1'b0;
      end
    endcase

    // A clear on the same edge as a set of that bit wins.
    pending_nxt = (pending | set_mask) & ~clr_mask;

`ifdef EMERGENCY_STOP_EN
    if (emergency) begin
      fsm_nxt        = fsm;
      travel_cnt_nxt = travel_cnt;
      door_cnt_nxt   = door_cnt;
      state_nxt      = state;
      open_door_nxt  = open_door;
      moving_nxt     = moving;
      direction_nxt  = direction;
      pending_nxt    = pending;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      travel_cnt <= '0;
      door_cnt   <= '0;
      state      <= ST_FLOOR;
      open_door  <= 1'b0;
      moving     <= 1'b0;
      direction  <= 1'b1;
      pending    <= 3'b000;
    end else begin
      fsm        <= fsm_nxt;
      travel_cnt <= travel_cnt_nxt;
      door_cnt   <= door_cnt_nxt;
      state      <= state_nxt;
      open_door  <= open_door_nxt;
      moving     <= moving_nxt;
      direction  <= direction_nxt;
      pending    <= pending_nxt;
    end
  end

endmodule
